// File: rtl/game_pkg.sv
// Shared game-mode encodings and button indices for the runner game.
package game_pkg;

  localparam logic [1:0] MODE_INIT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_PAUSE = 2'b10;
  localparam logic [1:0] MODE_END   = 2'b11;

  localparam int BTN_DIR   = 0;
  localparam int BTN_START = 1;
  localparam int BTN_END   = 2;

  typedef enum logic [1:0] {
    ST_INIT  = MODE_INIT,
    ST_RUN   = MODE_RUN,
    ST_PAUSE = MODE_PAUSE,
    ST_END   = MODE_END
  } mode_e;

endpackage

// File: rtl/game_ctrl_if.sv
// Button/collision inputs and mode/step/direction/score outputs of game_ctrl.
interface game_ctrl_if #(
  parameter int SCORE_W = 16
);
  logic [2:0]         btn;
  logic               collision;
  logic [1:0]         gamemode;
  logic               step;
  logic               dir;
  logic               world_clr;
  logic [SCORE_W-1:0] score;

  modport master (
    output btn, collision,
    input  gamemode, step, dir, world_clr, score
  );

  modport slave (
    input  btn, collision,
    output gamemode, step, dir, world_clr, score
  );
endinterface

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stability counter and a one-cycle
// registered press pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;

  assign w_differ = (r_sync2 != r_level);
  // r_cnt holds how many differing samples preceded the current one
  assign w_accept = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= w_accept & r_sync2;
      if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else if (w_differ) begin
        r_cnt <= r_cnt + CW'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/game_ctrl.sv
// Game-mode sequencer: debounced button events, frame divider, mode FSM,
// per-frame step strobe, player direction and saturating score.
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int FRAME_DIV       = 1_666_667,
  parameter int SCORE_W         = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  game_ctrl_if.slave  bus
);

  localparam int FW = $clog2(FRAME_DIV);
  localparam logic [FW-1:0]      FRAME_LAST = FW'(FRAME_DIV - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic [2:0]         w_press;
  logic [FW-1:0]      r_frame_cnt;
  logic               w_tick;
  mode_e              r_state;
  mode_e              w_state_next;
  logic               w_step_next;
  logic               w_clr_next;
  logic               w_dir_toggle;
  logic               r_step;
  logic               r_world_clr;
  logic               r_dir;
  logic [SCORE_W-1:0] r_score;

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (bus.btn[gi]),
      .o_press (w_press[gi])
    );
  end

  // Free-running: mode changes never realign the frame grid
  assign w_tick = (r_frame_cnt == FRAME_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_tick) begin
      r_frame_cnt <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Event priority inside each mode: end button, collision on tick, start, tick
  always_comb begin
    w_state_next = r_state;
    w_step_next  = 1'b0;
    w_clr_next   = 1'b0;
    w_dir_toggle = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (w_press[BTN_END]) begin
          w_clr_next = 1'b1;
        end else if (w_press[BTN_START]) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        w_dir_toggle = w_press[BTN_DIR];
        if (w_press[BTN_END]) begin
          w_state_next = ST_END;
        end else if (w_tick && bus.collision) begin
          w_state_next = ST_END;
        end else if (w_press[BTN_START]) begin
          w_state_next = ST_PAUSE;
        end else if (w_tick) begin
          w_step_next = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (w_press[BTN_END]) begin
          w_state_next = ST_END;
        end else if (w_press[BTN_START]) begin
          w_state_next = ST_RUN;
        end
      end
      ST_END: begin
        if (w_press[BTN_END]) begin
          w_state_next = ST_INIT;
          w_clr_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step      <= 1'b0;
      r_world_clr <= 1'b0;
      r_dir       <= 1'b0;
      r_score     <= '0;
    end else begin
      r_step      <= w_step_next;
      r_world_clr <= w_clr_next;
      if (w_clr_next) begin
        r_dir <= 1'b0;
      end else if (w_dir_toggle) begin
        r_dir <= ~r_dir;
      end
      if (w_clr_next) begin
        r_score <= '0;
      end else if (w_step_next && (r_score != SCORE_MAX)) begin
        r_score <= r_score + SCORE_W'(1);
      end
    end
  end

  assign bus.gamemode  = r_state;
  assign bus.step      = r_step;
  assign bus.dir       = r_dir;
  assign bus.world_clr = r_world_clr;
  assign bus.score     = r_score;

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized bench for game_ctrl: a behavioural model predicts every output
// event into a queue; an independent monitor pops and compares at negedge.
module tb_game_ctrl;

  localparam int D    = 4;
  localparam int FD   = 10;
  localparam int SW   = 3;
  localparam int SMAX = (1 << SW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_ctrl_if #(.SCORE_W(SW)) bus ();

  game_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .FRAME_DIV      (FD),
    .SCORE_W        (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  mode;
    logic        step;
    logic        dir;
    logic        clr;
    logic [SW-1:0] score;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ncyc  = 0;
  int   colmode = 0;

  // ---------------- reference model ----------------
  int         m_mode, m_score, m_edges;
  bit         m_step, m_dir, m_clr;
  bit         m_lvl   [3];
  bit         m_press [3];
  logic [D+1:0] m_hist [3];   // bit k = raw button seen k edges ago
  int         p_mode, p_score;
  bit         p_dir;

  task automatic model_reset();
    m_mode = 0; m_score = 0; m_edges = 0;
    m_step = 0; m_dir = 0; m_clr = 0;
    for (int b = 0; b < 3; b++) begin
      m_lvl[b] = 0; m_press[b] = 0; m_hist[b] = '0;
    end
  endtask

  task automatic push_if_event();
    obs_t e;
    if (m_step || m_clr || m_mode != p_mode || m_dir != p_dir || m_score != p_score) begin
      e.cyc   = ncyc + 1;
      e.mode  = m_mode[1:0];
      e.step  = m_step;
      e.dir   = m_dir;
      e.clr   = m_clr;
      e.score = m_score[SW-1:0];
      exp_q.push_back(e);
    end
    p_mode = m_mode; p_dir = m_dir; p_score = m_score;
  endtask

  task automatic model_edge();
    bit tick;
    int nm;
    logic [D-1:0] win;
    tick = (m_edges % FD) == FD - 1;
    nm = m_mode;
    m_step = 0; m_clr = 0;
    if (m_mode == 1 && m_press[0]) m_dir = !m_dir;
    case (m_mode)
      0: if (m_press[2]) m_clr = 1; else if (m_press[1]) nm = 1;
      1: if (m_press[2]) nm = 3;
         else if (tick && bus.collision) nm = 3;
         else if (m_press[1]) nm = 2;
         else if (tick) m_step = 1;
      2: if (m_press[2]) nm = 3; else if (m_press[1]) nm = 1;
      default: if (m_press[2]) begin nm = 0; m_clr = 1; end
    endcase
    if (m_clr) begin
      m_score = 0; m_dir = 0;
    end else if (m_step && m_score < SMAX) begin
      m_score++;
    end
    m_mode = nm;
    m_edges++;
    // accept a level once the last D synchronized samples all disagree with it
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = {m_hist[b][D:0], bus.btn[b]};
      win = m_hist[b][D+1:2];
      m_press[b] = 0;
      if (win == (m_lvl[b] ? {D{1'b0}} : {D{1'b1}})) begin
        m_lvl[b]   = !m_lvl[b];
        m_press[b] = m_lvl[b];
      end
    end
  endtask

  initial begin
    model_reset();
    p_mode = 0; p_dir = 0; p_score = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
      push_if_event();
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [1:0]    pm;
    logic          pd;
    logic [SW-1:0] ps;
    obs_t e;
    pm = 2'b00; pd = 1'b0; ps = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (bus.step === 1'b1 || bus.world_clr === 1'b1 || bus.gamemode !== pm ||
          bus.dir !== pd || bus.score !== ps) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event cyc=%0d got mode=%0d step=%0b dir=%0b clr=%0b score=%0d, required no event",
                   ncyc, bus.gamemode, bus.step, bus.dir, bus.world_clr, bus.score);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != ncyc || bus.gamemode !== e.mode || bus.step !== e.step ||
              bus.dir !== e.dir || bus.world_clr !== e.clr || bus.score !== e.score) begin
            fails++;
            $display("FAIL event got cyc=%0d mode=%0d step=%0b dir=%0b clr=%0b score=%0d, required cyc=%0d mode=%0d step=%0b dir=%0b clr=%0b score=%0d",
                     ncyc, bus.gamemode, bus.step, bus.dir, bus.world_clr, bus.score,
                     e.cyc, e.mode, e.step, e.dir, e.clr, e.score);
          end else begin
            $display("[TB] cyc=%0d mode=%0d step=%0b dir=%0b clr=%0b score=%0d ok",
                     ncyc, bus.gamemode, bus.step, bus.dir, bus.world_clr, bus.score);
          end
        end
        pm = bus.gamemode; pd = bus.dir; ps = bus.score;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [2:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
      bus.btn = b;
      case (colmode)
        1:       bus.collision = 1'b1;
        2:       bus.collision = ($urandom_range(0, 7) == 0);
        default: bus.collision = 1'b0;
      endcase
    end
  endtask

  task automatic check_mode(input string name, input logic [1:0] want);
    tests++;
    if (bus.gamemode !== want) begin
      fails++;
      $display("FAIL %s gamemode=%0d required=%0d", name, bus.gamemode, want);
    end else begin
      $display("[TB] %s gamemode=%0d ok", name, bus.gamemode);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    hold(3'b000, 3);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    int w;
    logic [2:0] b;
    bus.btn = 3'b000;
    bus.collision = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    tests++;
    if (bus.gamemode !== 2'b00 || bus.step !== 1'b0 || bus.dir !== 1'b0 ||
        bus.world_clr !== 1'b0 || bus.score !== '0) begin
      fails++;
      $display("FAIL reset_idle got mode=%0d step=%0b dir=%0b clr=%0b score=%0d, required all zero",
               bus.gamemode, bus.step, bus.dir, bus.world_clr, bus.score);
    end else begin
      $display("[TB] reset_idle ok");
    end

    // start latency: raw edge in cycle 0, mode changes in cycle D+3
    @(posedge clk);
    #2 bus.btn = 3'b010;
    for (int k = 0; k <= D + 3; k++) begin
      @(negedge clk);
      if (k == D + 2) check_mode("start_latency_before", 2'b00);
      if (k == D + 3) check_mode("start_latency_at", 2'b01);
    end
    hold(3'b010, 2);
    hold(3'b000, 50);

    // bounce shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      hold(3'b010, 2);
      hold(3'b000, 2);
    end
    hold(3'b000, 20);

    // pause, dir ignored, resume, dir toggles
    hold(3'b010, 8);  hold(3'b000, 50);
    hold(3'b001, 8);  hold(3'b000, 20);
    hold(3'b010, 8);  hold(3'b000, 20);
    hold(3'b001, 8);  hold(3'b000, 20);

    // collision -> END; start ignored; end button -> INIT with world_clr
    colmode = 1; hold(3'b000, 12); colmode = 0;
    hold(3'b010, 8);  hold(3'b000, 20);
    hold(3'b100, 8);  hold(3'b000, 20);

    // run into saturation, then start+end together
    hold(3'b010, 8);  hold(3'b000, 110);
    hold(3'b110, 8);  hold(3'b000, 20);

    // asynchronous reset in the middle of a run
    hold(3'b100, 8);  hold(3'b000, 15);
    hold(3'b010, 8);  hold(3'b000, 25);
    pulse_reset();
    hold(3'b000, 20);

    // randomized traffic
    for (int a = 0; a < 150; a++) begin
      r = $urandom_range(0, 99);
      colmode = ($urandom_range(0, 3) == 0) ? 2 : 0;
      if (r < 3) begin
        pulse_reset();
      end else if (r < 15) begin
        w = $urandom_range(1, D - 1);
        b = 3'b001 << $urandom_range(0, 2);
        hold(b, w);
        hold(3'b000, w);
        hold(b, w);
      end else begin
        if (r < 45)      b = 3'b010;
        else if (r < 70) b = 3'b001;
        else if (r < 85) b = 3'b100;
        else if (r < 92) b = 3'b110;
        else             b = 3'b111;
        hold(b, $urandom_range(D, 12));
      end
      hold(3'b000, $urandom_range(D + 2, 30));
    end
    colmode = 0;
    hold(3'b000, 30);
    @(negedge clk);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events left=%0d required=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level sequencer for the runner game. Turns the three raw push-buttons and the collision flag into a clean game-mode state machine, a per-frame advance strobe, a direction flag and a score counter. Its outputs drive the player-motion logic, the obstacle generator and the display overlay, so no downstream block sees raw buttons or keeps its own mode register.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples required to accept a button level (10 ms at 100 MHz).
- FRAME_DIV, 1_666_667: clocks per frame; gives a 60 Hz frame at 100 MHz. Minimum value is 2.
- SCORE_W, 16: score width.
- clk  in  1  system clock; all state is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn  in  3  raw, asynchronous, active-high buttons: [0] switch direction, [1] start/pause, [2] end/reset.
- collision  in  1  level from the collision checker; synchronous to clk.
- gamemode  out  2  00 INIT, 01 RUN, 10 PAUSE, 11 END; registered.
- step  out  1  one-cycle pulse; advance world by one frame. Asserted only in RUN.
- dir  out  1  player direction: 0 down, 1 up; registered.
- world_clr  out  1  one-cycle pulse; player and obstacles return to start positions.
- score  out  SCORE_W  number of frames survived; registered.

## Operation
- Per button: 2-flop synchronizer, then debounce.
  - Debounced level updates only after DEBOUNCE_CYCLES consecutive samples that differ from it.
  - A rising edge of the debounced level gives a one-cycle press event.
- Frame divider: free-running counter 0..FRAME_DIV-1. tick = (count == FRAME_DIV-1). It is not reset by mode changes.
- FSM (press events b0/b1/b2):
  - INIT: b1 -> RUN. b2 -> stay in INIT and pulse world_clr.
  - RUN: b2 -> END. Else, collision high on a tick -> END. Else b1 -> PAUSE. Else, on a tick, pulse step.
  - PAUSE: b2 -> END. b1 -> RUN.
  - END: b2 -> INIT and pulse world_clr. b1 is ignored.
- Priority when events coincide in one cycle: b2 > collision-on-tick > b1 > tick.
  - No step is issued in the cycle RUN is left.
- collision is sampled only on tick cycles while in RUN; it is ignored at all other times.
- dir toggles on b0 only in RUN. It is held in other modes and cleared to 0 by world_clr.
- score:
  - +1 on every step; saturates at 2^SCORE_W-1 (no wrap).
  - Cleared in the same cycle world_clr is asserted.
  - Held in PAUSE and END.
- Every press event is acted on exactly once. A held button produces no repeats.

## Timing
- Reset values: gamemode 00, step 0, dir 0, world_clr 0, score 0, debounced levels 0, frame counter 0.
- A button held through reset release produces one press event once debounced. This is intended.
- Button latency:
  - Raw edge at cycle 0 (held stable) -> press event at cycle DEBOUNCE_CYCLES+2.
  - gamemode, dir and world_clr change at cycle DEBOUNCE_CYCLES+3.
- step, world_clr and the score increment are registered. step and the score increment appear in the cycle after the tick that caused them.
- First tick after reset: cycle FRAME_DIV-1.
- Reset asserted mid-game: all outputs return to reset values immediately and asynchronously. No world_clr pulse is emitted.

## Structure
- Shared package game_pkg: MODE_INIT/MODE_RUN/MODE_PAUSE/MODE_END 2-bit constants and the btn index constants BTN_DIR/BTN_START/BTN_END. game_logic and the display logic use the same package.
- Sub-module btn_debounce: synchronizer, debounce counter and press-event edge detect; parameter DEBOUNCE_CYCLES. Instantiated three times.
- FSM, frame divider, dir and score stay in game_ctrl.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and FRAME_DIV=10.
- Reset, then idle 100 cycles -> gamemode 00, no step, score 0, dir 0.
- btn[1] held 10 cycles -> gamemode 01 exactly 7 cycles after the edge. After 50 further cycles, score is 5 and step pulses are exactly 10 cycles apart.
- Bounce: btn[1] toggled every 2 cycles for 20 cycles, then left low -> no mode change, no press event.
- RUN, then btn[1] -> 10. Over 50 cycles: no step, score held, and a btn[0] press leaves dir unchanged. btn[1] again -> 01; btn[0] -> dir 1.
- RUN with collision high on a tick -> 11 the next cycle, no step, score frozen, btn[1] ignored. btn[2] -> 00, a single-cycle world_clr, score 0, dir 0.
- RUN with btn[1] and btn[2] pressed in the same cycle -> 11. With SCORE_W=3, 9 steps -> score 7 (saturated).
